// File: rtl/fnd_scan_ctrl.sv
// Score-to-display front end: sequential double-dabble BCD conversion of a 14-bit
// score plus a 4-digit multiplexed scan with leading-zero blanking.
module fnd_scan_ctrl #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [13:0] i_score,
    input  logic        i_load,
    output logic        o_busy,
    output logic        o_ovf,
    output logic [3:0]  o_sel,
    output logic [3:0]  o_an
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CONV = 1'b1;
    localparam int         PW      = $clog2(SCAN_DIV);

    logic [0:0]    r_state;
    logic [13:0]   r_bin;
    logic [15:0]   r_bcd;
    logic [3:0]    r_cnt;
    logic          r_ovf_next;
    logic          r_ovf;
    logic [15:0]   r_disp;
    logic [PW-1:0] r_presc;
    logic [1:0]    r_idx;
    logic [3:0]    r_sel;
    logic [3:0]    r_an;

    logic [15:0]   w_adj;
    logic [15:0]   w_bcd_next;
    logic [3:0]    w_nib;
    logic          w_blank;
    logic [3:0]    w_an;

    // Add-3 correction on every nibble, then the shift pulls in the next binary MSB.
    always_comb begin
        w_adj = '0;
        for (int n = 0; n < 4; n++) begin
            w_adj[n*4 +: 4] = (r_bcd[n*4 +: 4] >= 4'd5) ? (r_bcd[n*4 +: 4] + 4'd3)
                                                        : r_bcd[n*4 +: 4];
        end
    end

    assign w_bcd_next = {w_adj[14:0], r_bin[13]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_bin      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_next <= 1'b0;
            r_ovf      <= 1'b0;
            r_disp     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_load) begin
                        r_state <= ST_CONV;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        if (i_score > 14'd9999) begin
                            r_bin      <= 14'd9999;
                            r_ovf_next <= 1'b1;
                        end else begin
                            r_bin      <= i_score;
                            r_ovf_next <= 1'b0;
                        end
                    end
                end
                ST_CONV: begin
                    r_bcd <= w_bcd_next;
                    r_bin <= {r_bin[12:0], 1'b0};
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd13) begin
                        r_disp  <= w_bcd_next;
                        r_ovf   <= r_ovf_next;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // A digit is blank when it and all higher digits are zero; the ones digit never is.
    always_comb begin
        w_nib   = 4'h0;
        w_blank = 1'b0;
        case (r_idx)
            2'd0: w_nib = r_disp[3:0];
            2'd1: begin
                w_nib   = r_disp[7:4];
                w_blank = (r_disp[15:4] == 12'd0);
            end
            2'd2: begin
                w_nib   = r_disp[11:8];
                w_blank = (r_disp[15:8] == 8'd0);
            end
            default: begin
                w_nib   = r_disp[15:12];
                w_blank = (r_disp[15:12] == 4'd0);
            end
        endcase
        w_an        = 4'b1111;
        w_an[r_idx] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_presc <= '0;
            r_idx   <= 2'd0;
            r_an    <= 4'b1110;
            r_sel   <= 4'h0;
        end else begin
            if (r_presc == PW'(SCAN_DIV - 1)) begin
                r_presc <= '0;
                r_idx   <= r_idx + 2'd1;
            end else begin
                r_presc <= r_presc + PW'(1);
            end
            r_an  <= w_an;
            r_sel <= w_blank ? 4'hF : w_nib;
        end
    end

    assign o_busy = (r_state == ST_CONV);
    assign o_ovf  = r_ovf;
    assign o_sel  = r_sel;
    assign o_an   = r_an;

endmodule
